alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Requester side of the ALU valid/ready interface. Accepts one RV32 instruction with its operands.
//  Decodes it and drives opcode/funct3/funct7/in_A/in_B with a one-cycle alu_valid pulse.
//  Waits for alu_ready, captures alu_out and presents a one-cycle register-file writeback.
//  Sits between the decode stage and the ALU; one instruction in flight at a time.
// PARAMETERS
//  TIMEOUT   16   max cycles in WAIT for alu_ready before aborting with err (1..255)
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  inst_valid  in   1   upstream has an instruction
//  inst_ready  out  1   controller accepts inst this cycle (inst_valid & inst_ready = accept)
//  inst        in   32  RV32 instruction word
//  rs1_data    in   32  value of rs1
//  rs2_data    in   32  value of rs2
//  alu_valid   out  1   request pulse to ALU
//  alu_opcode  out  7   inst[6:0] of the held instruction
//  alu_funct3  out  3   inst[14:12]
//  alu_funct7  out  7   inst[31:25]
//  alu_in_A    out  32  rs1_data
//  alu_in_B    out  32  R-type: rs2_data; I-type: {{20{inst[31]}},inst[31:20]}
//  alu_ready   in   1   ALU result valid on alu_out
//  alu_out     in   32  ALU result
//  wb_en       out  1   one-cycle writeback strobe
//  wb_rd       out  5   destination register inst[11:7]
//  wb_data     out  32  captured result
//  err         out  1   sticky: illegal instruction or ALU timeout; cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 except inst_ready=1. All holding regs are cleared.
//  Legal set: ADD (0110011/000/0000000), SUB (0110011/000/0100000), XOR (0110011/100/0000000).
//   ADDI (0010011/000, funct7 field don't-care).
//  States:
//   IDLE : inst_ready=1. On accept, latch inst/rs1/rs2 into holding regs. If legal, go to ISSUE.
//          If illegal, go to ERR. Otherwise stay in IDLE.
//   ISSUE: alu_valid=1 for exactly this cycle; alu_* driven from holding regs. Go to WAIT; clear cnt.
//   WAIT : alu_* held stable, alu_valid=0. cnt increments each cycle.
//          alu_ready=1 -> latch alu_out into wb_data; go to WB.
//          Else if cnt==TIMEOUT-1 -> go to ERR.
//   WB   : wb_en=1 and wb_rd valid for exactly one cycle. Go to IDLE.
//          If wb_rd==0, wb_en is forced to 0 (x0 is never written); still go to IDLE.
//   ERR  : err<=1; wb_en=0. Go to IDLE next cycle. The instruction is dropped.
//  inst_ready is 1 only in IDLE, so there is no accept while busy.
//  Min accept-to-wb_en latency = 3 cycles plus ALU latency. Best case: ISSUE, WAIT(ready), WB.
//  alu_ready is ignored outside WAIT. Accepting in the cycle after WB is legal (back-to-back).
//  alu_in_B sign-extension is done here; the ALU sees the full 32-bit immediate.
//  Asserting rst_n low in any state aborts immediately. No wb_en is issued for an aborted instruction.
// TESTING
//  ADD rd=5: rs1=7, rs2=3; ALU returns 10 on 2nd WAIT cycle.
//   -> alu_valid pulse 1 cycle, opcode 0110011; wb_en 1 cycle, wb_rd=5, wb_data=10.
//  ADDI rd=1, imm=0xFFF (-1), rs1=5.
//   -> alu_in_B=0xFFFFFFFF, funct3=000; wb_data equals alu_out captured.
//  Illegal (opcode 0000011) -> no alu_valid, err=1 from the following cycle, inst_ready back in 2 cycles.
//  alu_ready held 0 -> exactly TIMEOUT cycles in WAIT, then err=1, no wb_en. Next legal inst still completes.
//  rd=0 XOR -> ALU handshake completes, wb_en stays 0.
//   Then two back-to-back legal insts -> two wb_en pulses in order.
//  rst_n low during WAIT -> all outputs reset asynchronously, err=0, inst_ready=1. A late alu_ready is ignored.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: requester side of the ALU valid/ready handshake.
// Takes one RV32 ALU instruction at a time and decodes it. It issues the
// instruction to the ALU with a single-cycle alu_valid pulse, waits for the
// result and then presents a single-cycle register-file writeback. An illegal
// instruction or an ALU that never answers sets a sticky err flag; only reset
// clears that flag.
module alu_issue_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inst_valid,
   output logic        inst_ready,
   input  logic [31:0] inst,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic        alu_valid,
   output logic [6:0]  alu_opcode,
   output logic [2:0]  alu_funct3,
   output logic [6:0]  alu_funct7,
   output logic [31:0] alu_in_A,
   output logic [31:0] alu_in_B,
   input  logic        alu_ready,
   input  logic [31:0] alu_out,
   output logic        wb_en,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        err
);

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_WB,
      S_ERR
   } state_t;

   state_t      state, state_next;
   logic [31:0] inst_q, rs1_q, rs2_q, wb_data_q;
   logic [7:0]  cnt;
   logic        err_q;
   logic        accept;
   logic        legal;

   assign accept = inst_valid && (state == S_IDLE);

   // Decode the incoming word: only ADD, SUB, XOR and ADDI are accepted as legal.
   always_comb begin
      legal = 1'b0;
      if (inst[6:0] == OP_RTYPE) begin
         if (inst[14:12] == 3'b000)
            legal = (inst[31:25] == 7'b0000000) || (inst[31:25] == 7'b0100000);
         else if (inst[14:12] == 3'b100)
            legal = (inst[31:25] == 7'b0000000);
      end else if (inst[6:0] == OP_ITYPE) begin
         legal = (inst[14:12] == 3'b000);
      end
   end

   // Compute the next state and the strobes that depend on the state.
   always_comb begin
      state_next = state;
      inst_ready = 1'b0;
      alu_valid  = 1'b0;
      wb_en      = 1'b0;
      case (state)
         S_IDLE: begin
            inst_ready = 1'b1;
            if (inst_valid)
               state_next = legal ? S_ISSUE : S_ERR;
         end
         S_ISSUE: begin
            alu_valid  = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (alu_ready)
               state_next = S_WB;
            else if (cnt == CNT_LAST)
               state_next = S_ERR;
         end
         S_WB: begin
            wb_en      = (inst_q[11:7] != 5'd0);
            state_next = S_IDLE;
         end
         S_ERR: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Hold the state register; reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // Capture the instruction and its operands at accept so the ALU sees stable values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_q <= '0;
         rs1_q  <= '0;
         rs2_q  <= '0;
      end else if (accept) begin
         inst_q <= inst;
         rs1_q  <= rs1_data;
         rs2_q  <= rs2_data;
      end
   end

   // Count the cycles spent in WAIT; the ISSUE cycle restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (state == S_ISSUE)
         cnt <= '0;
      else if (state == S_WAIT)
         cnt <= cnt + 8'd1;
   end

   // Latch the ALU result in the cycle it is offered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wb_data_q <= '0;
      else if ((state == S_WAIT) && alu_ready)
         wb_data_q <= alu_out;
   end

   // Set the sticky error on entry to ERR so it is visible during the ERR cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= 1'b0;
      else if (state_next == S_ERR)
         err_q <= 1'b1;
   end

   assign alu_opcode = inst_q[6:0];
   assign alu_funct3 = inst_q[14:12];
   assign alu_funct7 = inst_q[31:25];
   assign alu_in_A   = rs1_q;
   assign alu_in_B   = (inst_q[6:0] == OP_ITYPE) ? {{20{inst_q[31]}}, inst_q[31:20]} : rs2_q;
   assign wb_rd      = inst_q[11:7];
   assign wb_data    = wb_data_q;
   assign err        = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl. The bench plays the ALU itself and keeps a
// scoreboard queue of expected writebacks, which a monitor checks in order.
module tb_alu_issue_ctrl;

   localparam int TO = 16;

   logic        clk;
   logic        rst_n;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        alu_valid;
   logic [6:0]  alu_opcode;
   logic [2:0]  alu_funct3;
   logic [6:0]  alu_funct7;
   logic [31:0] alu_in_A;
   logic [31:0] alu_in_B;
   logic        alu_ready;
   logic [31:0] alu_out;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        err;

   int errors = 0;
   int checks = 0;
   logic [36:0] exp_q[$];

   alu_issue_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .alu_valid(alu_valid), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
      .alu_funct7(alu_funct7), .alu_in_A(alu_in_A), .alu_in_B(alu_in_B),
      .alu_ready(alu_ready), .alu_out(alu_out),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Backstop in case a task loop misbehaves.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Scoreboard monitor: every writeback strobe must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && wb_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_wb: got rd=%0d data=%h, expected no writeback", wb_rd, wb_data);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            if ({wb_rd, wb_data} !== e) begin
               errors++;
               $display("[TB] FAIL wb_match: got rd=%0d data=%h, expected rd=%0d data=%h",
                        wb_rd, wb_data, e[36:32], e[31:0]);
            end
         end
      end
   end

   function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
      return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rd);
      return {imm, 5'd1, 3'b000, rd, 7'b0010011};
   endfunction

   // Present one instruction and return at the negedge right after it is accepted.
   task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
      int n;
      @(negedge clk);
      inst_valid = 1'b1;
      inst       = i;
      rs1_data   = a;
      rs2_data   = b;
      n = 0;
      while (!inst_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (inst_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL accept_wait: inst_ready=%b, expected 1 within 40 cycles", inst_ready);
      end
      @(negedge clk);
      inst_valid = 1'b0;
      inst       = '0;
      rs1_data   = '0;
      rs2_data   = '0;
   endtask

   // Act as the ALU: check the request and answer after a number of idle WAIT cycles.
   task automatic alu_respond(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] a, input logic [31:0] b,
                              input int idle, input logic [31:0] result);
      int n;
      n = 0;
      while (!alu_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (alu_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL alu_valid_seen: got %b, expected 1", alu_valid);
      end
      checks++;
      if ({alu_opcode, alu_funct3, alu_funct7} !== {op, f3, f7}) begin
         errors++;
         $display("[TB] FAIL alu_fields: got op=%b f3=%b f7=%b, expected op=%b f3=%b f7=%b",
                  alu_opcode, alu_funct3, alu_funct7, op, f3, f7);
      end
      checks++;
      if ({alu_in_A, alu_in_B} !== {a, b}) begin
         errors++;
         $display("[TB] FAIL alu_operands: got A=%h B=%h, expected A=%h B=%h", alu_in_A, alu_in_B, a, b);
      end
      @(negedge clk);
      checks++;
      if (alu_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL alu_valid_pulse: got %b in WAIT, expected 0", alu_valid);
      end
      repeat (idle) @(negedge clk);
      checks++;
      if (alu_in_B !== b) begin
         errors++;
         $display("[TB] FAIL alu_hold: got B=%h during WAIT, expected %h", alu_in_B, b);
      end
      alu_ready = 1'b1;
      alu_out   = result;
      @(negedge clk);
      alu_ready = 1'b0;
      alu_out   = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({inst_ready, alu_valid, wb_en, err} !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got ready/valid/wb/err=%b, expected 1000",
                  {inst_ready, alu_valid, wb_en, err});
      end
      checks++;
      if ({alu_opcode, alu_funct3, alu_funct7, alu_in_A, alu_in_B, wb_rd, wb_data} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_data: got A=%h B=%h wb_data=%h, expected all zero", alu_in_A, alu_in_B, wb_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      exp_q.push_back({5'd5, 32'd10});
      issue(r_type(7'b0000000, 3'b000, 5'd5), 32'd7, 32'd3);
      alu_respond(7'b0110011, 3'b000, 7'b0000000, 32'd7, 32'd3, 1, 32'd10);
      checks++;
      if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd5, 32'd10}) begin
         errors++;
         $display("[TB] FAIL add_wb: got en=%b rd=%0d data=%0d, expected en=1 rd=5 data=10", wb_en, wb_rd, wb_data);
      end
      @(negedge clk);
      checks++;
      if ({wb_en, inst_ready} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL add_wb_pulse: got wb_en/inst_ready=%b, expected 01", {wb_en, inst_ready});
      end
   endtask

   task automatic test_addi();
      exp_q.push_back({5'd1, 32'd4});
      issue(i_type(12'hFFF, 5'd1), 32'd5, 32'hDEADBEEF);
      alu_respond(7'b0010011, 3'b000, 7'h7F, 32'd5, 32'hFFFFFFFF, 0, 32'd4);
   endtask

   task automatic test_rd0();
      issue(r_type(7'b0000000, 3'b100, 5'd0), 32'hF0F0F0F0, 32'h0F0F0F0F);
      alu_respond(7'b0110011, 3'b100, 7'b0000000, 32'hF0F0F0F0, 32'h0F0F0F0F, 2, 32'hFFFFFFFF);
      checks++;
      if ({wb_en, inst_ready, wb_data} !== {2'b00, 32'hFFFFFFFF}) begin
         errors++;
         $display("[TB] FAIL rd0_wb: got wb_en=%b inst_ready=%b data=%h, expected 0 0 ffffffff",
                  wb_en, inst_ready, wb_data);
      end
   endtask

   task automatic test_back_to_back();
      exp_q.push_back({5'd3, 32'd12});
      exp_q.push_back({5'd4, 32'h00000800});
      issue(r_type(7'b0100000, 3'b000, 5'd3), 32'd20, 32'd8);
      alu_respond(7'b0110011, 3'b000, 7'b0100000, 32'd20, 32'd8, 0, 32'd12);
      issue(i_type(12'h7FF, 5'd4), 32'd1, 32'd99);
      alu_respond(7'b0010011, 3'b000, 7'h3F, 32'd1, 32'h000007FF, 0, 32'h00000800);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL b2b_drain: got %0d pending writebacks, expected 0", exp_q.size());
      end
   endtask

   task automatic test_illegal();
      issue({12'h000, 5'd1, 3'b010, 5'd6, 7'b0000011}, 32'd1, 32'd2);
      checks++;
      if ({alu_valid, err, inst_ready} !== 3'b010) begin
         errors++;
         $display("[TB] FAIL illegal_err: got valid/err/ready=%b, expected 010", {alu_valid, err, inst_ready});
      end
      @(negedge clk);
      checks++;
      if ({alu_valid, err, inst_ready} !== 3'b011) begin
         errors++;
         $display("[TB] FAIL illegal_ready: got valid/err/ready=%b, expected 011", {alu_valid, err, inst_ready});
      end
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      issue(r_type(7'b0000000, 3'b000, 5'd7), 32'd1, 32'd1);
      n = 0;
      while (!alu_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      @(negedge clk);
      while (!inst_ready && !err && n < 100) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != TO) begin
         errors++;
         $display("[TB] FAIL timeout_len: got %0d WAIT cycles, expected %0d", n, TO);
      end
      checks++;
      if ({err, inst_ready} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL timeout_err: got err/ready=%b, expected 10", {err, inst_ready});
      end
      exp_q.push_back({5'd9, 32'd33});
      issue(r_type(7'b0000000, 3'b000, 5'd9), 32'd30, 32'd3);
      alu_respond(7'b0110011, 3'b000, 7'b0000000, 32'd30, 32'd3, 3, 32'd33);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL timeout_recover: got pending=%0d err=%b, expected 0 1", exp_q.size(), err);
      end
   endtask

   task automatic test_reset_in_wait();
      int n;
      issue(r_type(7'b0000000, 3'b000, 5'd8), 32'd4, 32'd4);
      n = 0;
      while (!alu_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({inst_ready, alu_valid, wb_en, err, alu_in_A, alu_opcode} !== {4'b1000, 39'd0}) begin
         errors++;
         $display("[TB] FAIL async_reset: got ready/valid/wb/err=%b A=%h op=%b, expected 1000 0 0",
                  {inst_ready, alu_valid, wb_en, err}, alu_in_A, alu_opcode);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      alu_ready = 1'b1;
      alu_out   = 32'h12345678;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({inst_ready, alu_valid, wb_en, err, wb_data} !== {4'b1000, 32'd0}) begin
            errors++;
            $display("[TB] FAIL late_ready: got ready/valid/wb/err=%b data=%h, expected 1000 0",
                     {inst_ready, alu_valid, wb_en, err}, wb_data);
         end
      end
      alu_ready = 1'b0;
      alu_out   = '0;
   endtask

   // Run every scenario in order, then print the summary.
   initial begin
      inst_valid = 1'b0;
      inst       = '0;
      rs1_data   = '0;
      rs2_data   = '0;
      alu_ready  = 1'b0;
      alu_out    = '0;
      test_reset();
      test_add();
      test_addi();
      test_rd0();
      test_back_to_back();
      test_illegal();
      test_timeout();
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
